// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path.
//   FRAME_BITS / CH_BITS : serial frame geometry (two 16-bit channels).
//   LAST_BIT / RIGHT_BIT : bit-counter values at which the frame reloads
//                          and the right channel starts.
//   state_t              : serializer run state.
package audio_pkg;

  localparam int FRAME_BITS = 32;
  localparam int CH_BITS    = 16;

  localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);
  localparam logic [4:0] RIGHT_BIT = 5'(CH_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dac_serializer_bclk_gen.sv
// Bit-clock generator: divides clk by 2*DIV while i_run is high.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_run   : count enable; low holds the divider and bclk at 0
//   o_bclk  : registered bit clock
//   o_rise  : one-clk strobe in the cycle before bclk rises
//   o_fall  : one-clk strobe in the cycle before bclk falls
module bclk_gen
  import audio_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] DCNT_LAST = 8'(DIV - 1);

  logic [7:0] r_dcnt;
  logic       r_bclk;
  logic       w_tick;

  assign w_tick = i_run & (r_dcnt == DCNT_LAST);

  // Divider counter and bclk toggle flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt <= 8'd0;
      r_bclk <= 1'b0;
    end else if (!i_run) begin
      r_dcnt <= 8'd0;
      r_bclk <= 1'b0;
    end else if (w_tick) begin
      r_dcnt <= 8'd0;
      r_bclk <= ~r_bclk;
    end else begin
      r_dcnt <= r_dcnt + 8'd1;
      r_bclk <= r_bclk;
    end
  end

  assign o_bclk = r_bclk;
  assign o_rise = w_tick & ~r_bclk;
  assign o_fall = w_tick & r_bclk;

endmodule

// File: rtl/dac_serializer.sv
// Left-justified stereo serializer feeding the audio DAC. Requests one
// sample per frame from the DDS, holds the returned sample and shifts it
// MSB-first on both channels.
//   clk, reset      : system clock, asynchronous active-low reset
//   enable          : run request; stopping takes effect at frame end
//   sample_in       : two's-complement sample from the DDS
//   sample_valid    : one-clk strobe, sample_in is new
//   sample_req      : one-clk request strobe after each frame load
//   bclk/lrclk/sdata: serial link (lrclk 0 = left)
//   underrun        : frame loaded without a fresh sample
//   overrun         : fresh sample overwritten before being consumed
module dac_serializer
  import audio_pkg::*;
#(
  parameter int W   = 16,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] sample_in,
  input  logic         sample_valid,
  output logic         sample_req,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic         underrun,
  output logic         overrun
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [4:0]   r_bitcnt;
  logic [4:0]   w_bitcnt_nxt;
  logic [W-1:0] r_shreg;
  logic [W-1:0] w_shreg_nxt;
  logic [W-1:0] r_frame;
  logic [W-1:0] w_frame_nxt;
  logic [W-1:0] r_hold;
  logic [W-1:0] w_hold_nxt;
  logic         r_fresh;
  logic         w_fresh_nxt;
  logic         r_sdata;
  logic         r_sample_req;
  logic         r_underrun;
  logic         r_overrun;
  logic         w_load;
  logic         w_underrun_nxt;
  logic         w_overrun_nxt;
  logic [W-1:0] w_sample_sel;
  logic         w_run;
  logic         w_bclk;
  logic         w_bclk_fall;
  logic         w_rise_unused;

  assign w_run = (r_state == RUN);

  // The rising strobe has no consumer here; data only moves on falling ticks.
  bclk_gen #(
    .DIV(DIV)
  ) u_bclk_gen (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_run  (w_run),
    .o_bclk (w_bclk),
    .o_rise (w_rise_unused),
    .o_fall (w_bclk_fall)
  );

  // A sample arriving in the load cycle bypasses hold so it is not lost.
  assign w_sample_sel = sample_valid ? sample_in : r_hold;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, frame sequencing, sample capture and flag decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shreg_nxt    = r_shreg;
    w_frame_nxt    = r_frame;
    w_hold_nxt     = r_hold;
    w_fresh_nxt    = r_fresh;
    w_load         = 1'b0;
    w_underrun_nxt = 1'b0;
    w_overrun_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_bitcnt_nxt = 5'd0;
        w_shreg_nxt  = {W{1'b0}};
        if (enable) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_bclk_fall) begin
          w_bitcnt_nxt = r_bitcnt + 5'd1;
          if (r_bitcnt == LAST_BIT) begin
            // Frame boundary: either start the next frame or stop cleanly.
            if (enable) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_shreg_nxt = {W{1'b0}};
            end
          end else if (r_bitcnt == RIGHT_BIT) begin
            // Right channel resends the same sample from the frame copy.
            w_shreg_nxt = r_frame;
          end else begin
            w_shreg_nxt = {r_shreg[W-2:0], 1'b0};
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_load) begin
      w_shreg_nxt    = w_sample_sel;
      w_frame_nxt    = w_sample_sel;
      w_underrun_nxt = ~(sample_valid | r_fresh);
    end else begin
      w_frame_nxt = r_frame;
    end

    if (sample_valid) begin
      w_hold_nxt    = sample_in;
      w_fresh_nxt   = 1'b1;
      w_overrun_nxt = r_fresh & ~w_load;
    end else begin
      w_hold_nxt = r_hold;
    end

    // A load consumes whatever is fresh, including a same-cycle bypass.
    if (w_load) begin
      w_fresh_nxt = 1'b0;
    end else begin
      w_fresh_nxt = w_fresh_nxt;
    end
  end

  // Datapath, counters and registered output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitcnt     <= 5'd0;
      r_shreg      <= {W{1'b0}};
      r_frame      <= {W{1'b0}};
      r_hold       <= {W{1'b0}};
      r_fresh      <= 1'b0;
      r_sdata      <= 1'b0;
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_bitcnt     <= w_bitcnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_frame      <= w_frame_nxt;
      r_hold       <= w_hold_nxt;
      r_fresh      <= w_fresh_nxt;
      r_sdata      <= w_shreg_nxt[W-1];
      r_sample_req <= w_load;
      r_underrun   <= w_underrun_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign sample_req = r_sample_req;
  assign bclk       = w_bclk;
  assign lrclk      = r_bitcnt[4];
  assign sdata      = r_sdata;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule
